// File: rtl/ad7643_slave_emu.sv
// AD7643 slave emulator: answers convert requests from an SPI-style master
// with a busy pulse, then serves the converted word MSB first on ADSDOUT.
// Optional build macro EMU_RAMP_EN: convert an internal incrementing ramp
// instead of the SAMPLE input.
// Handshake: a conversion is requested by a falling ADCNVST; the frame is
// owned by the master while ADCS is low, data changes after each ADSCLK
// falling edge and is stable for the master's ADSCLK rising edge.
module ad7643_slave_emu #(
    parameter int CONV_CYCLES = 20,
    parameter int DATA_WIDTH  = 18
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ADCNVST,
    input  logic                  ADCS,
    input  logic                  ADSCLK,
    input  logic [DATA_WIDTH-1:0] SAMPLE,
    output logic                  ADBUSY,
    output logic                  ADSDOUT,
    output logic                  ADSYNC,
    output logic                  OVR,
    output logic [15:0]           NCONV,
    output logic [1:0]            DBG_STATE
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READY = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    // bit 0: first flop, bit 1: synchronized level, bit 2: previous level
    logic [2:0]            cnvst_q, cs_q, sclk_q;
    logic [7:0]            busy_cnt_q, busy_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [15:0]           nconv_q, nconv_d;
    logic                  ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0] data_word;
    logic                  cnvst_fall, sclk_fall, cs_n;

    assign cnvst_fall = cnvst_q[2] & ~cnvst_q[1];
    assign sclk_fall  = sclk_q[2] & ~sclk_q[1];
    assign cs_n       = cs_q[1];

`ifdef EMU_RAMP_EN
    logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
    logic                  sample_unused;

    assign sample_unused = ^SAMPLE;
    assign data_word     = ramp_q;

    // Ramp value advances once per completed conversion.
    always_ff @(posedge CLK) begin
        if (RST) ramp_q <= '0;
        else     ramp_q <= ramp_d;
    end

    // Ramp next value, wrapping naturally at all-ones.
    always_comb begin
        ramp_d = ramp_q;
        if (state_q == CONV && busy_cnt_q == 8'd1) ramp_d = ramp_q + 1'b1;
    end
`else
    assign data_word = SAMPLE;
`endif

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnvst_q <= '0;
            cs_q    <= '0;
            sclk_q  <= '0;
        end else begin
            cnvst_q <= {cnvst_q[1:0], ADCNVST};
            cs_q    <= {cs_q[1:0], ADCS};
            sclk_q  <= {sclk_q[1:0], ADSCLK};
        end
    end

    // State, counters, shift register and status registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            nconv_q    <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            nconv_q    <= nconv_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic; a convert request outside IDLE is dropped and flagged.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        nconv_d    = nconv_q;
        ovr_d      = ovr_q | (cnvst_fall && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (cnvst_fall) begin
                    shift_d    = data_word;
                    busy_cnt_d = 8'(CONV_CYCLES);
                    state_d    = CONV;
                end
            end
            CONV: begin
                busy_cnt_d = busy_cnt_q - 8'd1;
                if (busy_cnt_q == 8'd1) begin
                    nconv_d = nconv_q + 16'd1;
                    state_d = READY;
                end
            end
            READY: begin
                if (!cs_n) begin
                    bit_cnt_d = BW'(DATA_WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Chip select high freezes the frame in place.
                if (!cs_n && sclk_fall) begin
                    shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    if (bit_cnt_q == BW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ADBUSY    = (state_q == CONV);
    assign ADSYNC    = (state_q == SHIFT);
    assign ADSDOUT   = (state_q == SHIFT) && !cs_n && shift_q[DATA_WIDTH-1];
    assign OVR       = ovr_q;
    assign NCONV     = nconv_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ad7643_slave_emu.sv
// Directed bench for ad7643_slave_emu with default parameters.
module tb_ad7643_slave_emu;

    localparam bit RAMP =
`ifdef EMU_RAMP_EN
        1'b1;
`else
        1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        ADCNVST;
    logic        ADCS;
    logic        ADSCLK;
    logic [17:0] SAMPLE;
    logic        ADBUSY, ADSDOUT, ADSYNC, OVR;
    logic [15:0] NCONV;
    logic [1:0]  DBG_STATE;

    int          total = 0;
    int          bad = 0;
    logic [17:0] ramp_m;
    logic [17:0] w, dummy, expw_v;
    int          cnt;

    ad7643_slave_emu dut (
        .CLK(CLK), .RST(RST), .ADCNVST(ADCNVST), .ADCS(ADCS), .ADSCLK(ADSCLK),
        .SAMPLE(SAMPLE), .ADBUSY(ADBUSY), .ADSDOUT(ADSDOUT), .ADSYNC(ADSYNC),
        .OVR(OVR), .NCONV(NCONV), .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] expw(input logic [17:0] s);
        return RAMP ? ramp_m : s;
    endfunction

    // Falling ADCNVST, then count the cycles ADBUSY stays high (bounded).
    task automatic convert(output int c);
        ADCNVST = 1'b0;
        tick(3);
        ADCNVST = 1'b1;
        c = 0;
        while (ADBUSY === 1'b1 && c < 300) begin
            tick(1);
            c++;
        end
    endtask

    // One SCLK pulse per bit; master samples at the rising edge.
    task automatic sclk_bits(input int k, input logic [17:0] wi, output logic [17:0] wo);
        wo = wi;
        for (int i = 0; i < k; i++) begin
            ADSCLK = 1'b1;
            tick(4);
            wo = {wo[16:0], ADSDOUT};
            ADSCLK = 1'b0;
            tick(4);
        end
    endtask

    task automatic do_frame(input logic [17:0] s, input string tag);
        logic [17:0] e, r;
        int c;
        SAMPLE = s;
        e = expw(s);
        convert(c);
        ramp_m = ramp_m + 1'b1;
        check({tag, "_busy"}, c, 20);
        ADCS = 1'b0;
        tick(4);
        check({tag, "_sync"}, ADSYNC, 1'b1);
        sclk_bits(18, 18'h0, r);
        check({tag, "_word"}, r, e);
        check({tag, "_end"}, ADSYNC, 1'b0);
        ADCS = 1'b1;
        tick(4);
    endtask

    initial begin
        RST = 1'b1; ADCNVST = 1'b1; ADCS = 1'b1; ADSCLK = 1'b0; SAMPLE = '0;
        ramp_m = '0;
        tick(3);
        check("rst_busy", ADBUSY, 1'b0);
        check("rst_sync", ADSYNC, 1'b0);
        check("rst_sdout", ADSDOUT, 1'b0);
        check("rst_ovr", OVR, 1'b0);
        check("rst_nconv", NCONV, 16'd0);
        check("rst_state", DBG_STATE, 2'd0);
        RST = 1'b0;
        tick(3);

        // Basic conversion with latency, busy width and full readout.
        SAMPLE = 18'h2A5A5;
        expw_v = expw(SAMPLE);
        ADCNVST = 1'b0;
        tick(2);
        check("lat2_busy", ADBUSY, 1'b0);
        tick(1);
        check("lat3_busy", ADBUSY, 1'b1);
        ADCNVST = 1'b1;
        cnt = 0;
        while (ADBUSY === 1'b1 && cnt < 300) begin
            tick(1);
            cnt++;
        end
        ramp_m = ramp_m + 1'b1;
        check("basic_busy", cnt, 20);
        check("basic_nconv", NCONV, 16'd1);
        check("ready_sync", ADSYNC, 1'b0);
        sclk_bits(2, 18'h0, dummy);    // SCLK ignored in READY
        check("ready_hold", ADSYNC, 1'b0);
        ADCS = 1'b0;
        tick(4);
        check("basic_sync", ADSYNC, 1'b1);
        sclk_bits(18, 18'h0, w);
        check("basic_word", w, expw_v);
        check("basic_end_sync", ADSYNC, 1'b0);
        check("basic_end_sdout", ADSDOUT, 1'b0);
        ADCS = 1'b1;
        tick(4);

        // Back-to-back conversions.
        do_frame(18'h3FFFF, "b2b0");
        do_frame(18'h00001, "b2b1");
        check("b2b_nconv", NCONV, 16'd3);
        check("b2b_ovr", OVR, 1'b0);

        // Lost convert request during CONV.
        SAMPLE = 18'h15A3C;
        expw_v = expw(SAMPLE);
        ADCNVST = 1'b0;
        tick(3);
        ADCNVST = 1'b1;
        tick(3);
        ADCNVST = 1'b0;
        tick(3);
        ADCNVST = 1'b1;
        cnt = 0;
        while (ADBUSY === 1'b1 && cnt < 300) begin
            tick(1);
            cnt++;
        end
        ramp_m = ramp_m + 1'b1;
        check("ovr_busy", cnt + 6, 20);
        check("ovr_flag", OVR, 1'b1);
        check("ovr_nconv", NCONV, 16'd4);
        ADCS = 1'b0;
        tick(4);
        sclk_bits(18, 18'h0, w);
        check("ovr_word", w, expw_v);
        ADCS = 1'b1;
        tick(10);
        check("ovr_no_restart", ADBUSY, 1'b0);
        check("ovr_sticky", OVR, 1'b1);

        // Chip select pause mid-frame; SCLK while paused must not shift.
        SAMPLE = 18'h1C3E7;
        expw_v = expw(SAMPLE);
        convert(cnt);
        ramp_m = ramp_m + 1'b1;
        ADCS = 1'b0;
        tick(4);
        sclk_bits(9, 18'h0, w);
        ADCS = 1'b1;
        tick(4);
        check("pause_sdout", ADSDOUT, 1'b0);
        check("pause_sync", ADSYNC, 1'b1);
        sclk_bits(2, 18'h0, dummy);
        tick(30);
        check("pause_sdout2", ADSDOUT, 1'b0);
        ADCS = 1'b0;
        tick(4);
        sclk_bits(9, w, w);
        check("pause_word", w, expw_v);
        check("pause_end", ADSYNC, 1'b0);
        ADCS = 1'b1;
        tick(4);

        // Reset mid-shift.
        SAMPLE = 18'h2B7E1;
        convert(cnt);
        ADCS = 1'b0;
        tick(4);
        sclk_bits(5, 18'h0, dummy);
        RST = 1'b1;
        tick(1);
        check("mrst_busy", ADBUSY, 1'b0);
        check("mrst_sync", ADSYNC, 1'b0);
        check("mrst_sdout", ADSDOUT, 1'b0);
        check("mrst_ovr", OVR, 1'b0);
        check("mrst_nconv", NCONV, 16'd0);
        RST = 1'b0;
        ADCS = 1'b1;
        ramp_m = '0;
        tick(4);
        do_frame(18'h0F0F0, "fresh");
        check("fresh_nconv", NCONV, 16'd1);
        check("fresh_ovr", OVR, 1'b0);

        // Convert request coinciding with the last SCLK falling edge.
        SAMPLE = 18'h3C3C3;
        expw_v = expw(SAMPLE);
        convert(cnt);
        ramp_m = ramp_m + 1'b1;
        ADCS = 1'b0;
        tick(4);
        sclk_bits(17, 18'h0, w);
        ADSCLK = 1'b1;
        tick(4);
        w = {w[16:0], ADSDOUT};
        ADSCLK = 1'b0;
        ADCNVST = 1'b0;
        tick(4);
        ADCNVST = 1'b1;
        check("same_word", w, expw_v);
        check("same_ovr", OVR, 1'b1);
        check("same_sync", ADSYNC, 1'b0);
        tick(10);
        check("same_no_conv", ADBUSY, 1'b0);
        check("same_nconv", NCONV, 16'd2);
        ADCS = 1'b1;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
